// File: rtl/mux_pkg.sv
// Shared types, baud divider constants and framing helpers for the MUX serial
// board receive channel.
package mux_pkg;

  typedef enum logic [2:0] {
    WAIT_HIGH = 3'd0,
    IDLE      = 3'd1,
    START     = 3'd2,
    DATA      = 3'd3,
    PARITY    = 3'd4,
    STOP1     = 3'd5,
    STOP2     = 3'd6
  } rx_state_t;

  localparam int unsigned BIT_CLOCK_HZ = 32'd27_000_000;

  // bit_clock cycles per bit for the standard baud rates
  localparam int unsigned DIV_75    = BIT_CLOCK_HZ / 32'd75;
  localparam int unsigned DIV_150   = BIT_CLOCK_HZ / 32'd150;
  localparam int unsigned DIV_300   = BIT_CLOCK_HZ / 32'd300;
  localparam int unsigned DIV_600   = BIT_CLOCK_HZ / 32'd600;
  localparam int unsigned DIV_1200  = BIT_CLOCK_HZ / 32'd1200;
  localparam int unsigned DIV_2400  = BIT_CLOCK_HZ / 32'd2400;
  localparam int unsigned DIV_4800  = BIT_CLOCK_HZ / 32'd4800;
  localparam int unsigned DIV_9600  = BIT_CLOCK_HZ / 32'd9600;
  localparam int unsigned DIV_19200 = BIT_CLOCK_HZ / 32'd19200;
  localparam int unsigned DIV_38400 = BIT_CLOCK_HZ / 32'd38400;

  localparam int unsigned DIV_MIN     = 32'd4;
  localparam int unsigned DATA_W      = 32'd8;
  localparam int unsigned DATA_BITS_W = 32'd4;
  localparam int unsigned ENTRY_W     = 32'd10;

  localparam logic [3:0] DATA_BITS_MIN = 4'd5;
  localparam logic [3:0] DATA_BITS_MAX = 4'd8;

  typedef struct packed {
    logic       ferr;
    logic       perr;
    logic [7:0] data;
  } rx_entry_t;

  function automatic logic [3:0] clamp_data_bits(input logic [3:0] bits);
    logic [3:0] res;
    if (bits < DATA_BITS_MIN) begin
      res = DATA_BITS_MIN;
    end else if (bits > DATA_BITS_MAX) begin
      res = DATA_BITS_MAX;
    end else begin
      res = bits;
    end
    return res;
  endfunction

  // Unused data bits are held at zero, so a full-width reduction is safe.
  function automatic logic parity_mismatch(input logic [7:0] data, input logic pbit,
                                           input logic odd);
    return ((^data) ^ pbit) != odd;
  endfunction

endpackage

// File: rtl/mux_rx_fifo.sv
// Small synchronous FIFO holding received characters with their error flags;
// the head entry reads as zero while empty.
module mux_rx_fifo
  import mux_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int WIDTH      = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty,
  output logic             drop
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic [AW:0]      wr_ptr_r;
  logic [AW:0]      rd_ptr_r;
  logic [WIDTH-1:0] mem_r [FIFO_DEPTH];
  logic             do_pop_s;
  logic             do_push_s;

  assign empty     = (wr_ptr_r == rd_ptr_r);
  assign full      = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                     (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
  assign do_pop_s  = pop && !empty;
  // A push into a full FIFO still lands when the head is popped in the same cycle.
  assign do_push_s = push && (!full || do_pop_s);
  assign drop      = push && full && !do_pop_s;

  // Pointer update
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_r <= {(AW+1){1'b0}};
      rd_ptr_r <= {(AW+1){1'b0}};
    end else begin
      if (do_push_s) begin
        wr_ptr_r <= wr_ptr_r + {{AW{1'b0}}, 1'b1};
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + {{AW{1'b0}}, 1'b1};
      end
    end
  end

  // Storage write
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_r[wr_ptr_r[AW-1:0]] <= push_data;
    end
  end

  // Head entry, forced to zero while empty
  always_comb begin
    head = {WIDTH{1'b0}};
    if (empty) begin
      head = {WIDTH{1'b0}};
    end else begin
      head = mem_r[rd_ptr_r[AW-1:0]];
    end
  end

endmodule

// File: rtl/mux_uart_rx.sv
// Receive channel of the MUX serial board: deserialises the async line with
// configurable framing and queues characters plus error flags for the CPU.
module mux_uart_rx
  import mux_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int DIV_W      = 16
) (
  input  logic             bit_clock,
  input  logic             reset,
  input  logic             uart_rx,
  input  logic [DIV_W-1:0] divider,
  input  logic [3:0]       data_bits,
  input  logic             parity_enabled,
  input  logic             parity_odd,
  input  logic             stop_bits,
  input  logic             rd_en,
  input  logic             clear_overrun,
  output logic [7:0]       rx_data,
  output logic             rx_valid,
  output logic             parity_error,
  output logic             framing_error,
  output logic             overrun,
  output logic             rx_busy
);

  localparam logic [DIV_W-1:0] DIV_FLOOR = DIV_W'(DIV_MIN);
  localparam logic [DIV_W-1:0] CNT_ONE   = DIV_W'(1);

  logic             sync1_r;
  logic             rxs_r;
  rx_state_t        state_r;
  rx_state_t        state_next_s;
  logic [DIV_W-1:0] cnt_r;
  logic [DIV_W-1:0] div_l_r;
  logic [DIV_W-1:0] div_eff_s;
  logic [DIV_W-1:0] target_s;
  logic [3:0]       nbits_l_r;
  logic             par_en_l_r;
  logic             par_odd_l_r;
  logic             stop2_l_r;
  logic [2:0]       idx_r;
  logic [7:0]       shift_r;
  logic             perr_r;
  logic             sample_s;
  logic             last_bit_s;
  logic             push_s;
  logic             ferr_s;
  logic             start_s;
  rx_entry_t        push_entry_s;
  rx_entry_t        head_s;
  logic             fifo_full_s;
  logic             fifo_empty_s;
  logic             drop_s;
  logic             busy_r;
  logic             overrun_r;

  // Two-flop synchroniser, idle-high preset
  always_ff @(posedge bit_clock) begin
    if (reset) begin
      sync1_r <= 1'b1;
      rxs_r   <= 1'b1;
    end else begin
      sync1_r <= uart_rx;
      rxs_r   <= sync1_r;
    end
  end

  assign start_s = (state_r == IDLE) && !rxs_r;

  // Sample-point timing: half a bit into START, then a full bit period
  always_comb begin
    div_eff_s  = divider;
    target_s   = div_l_r;
    if (divider < DIV_FLOOR) begin
      div_eff_s = DIV_FLOOR;
    end else begin
      div_eff_s = divider;
    end
    if (state_r == START) begin
      target_s = {1'b0, div_l_r[DIV_W-1:1]};
    end else begin
      target_s = div_l_r;
    end
    sample_s   = (cnt_r == (target_s - CNT_ONE));
    last_bit_s = ({1'b0, idx_r} == (nbits_l_r - 4'd1));
  end

  // Receiver state register
  always_ff @(posedge bit_clock) begin
    if (reset) begin
      state_r <= WAIT_HIGH;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state and push decode
  always_comb begin
    state_next_s = state_r;
    push_s       = 1'b0;
    ferr_s       = 1'b0;
    case (state_r)
      WAIT_HIGH: begin
        if (rxs_r) state_next_s = IDLE;
        else       state_next_s = WAIT_HIGH;
      end
      IDLE: begin
        if (!rxs_r) state_next_s = START;
        else        state_next_s = IDLE;
      end
      START: begin
        if (sample_s) begin
          if (rxs_r) state_next_s = IDLE;
          else       state_next_s = DATA;
        end else begin
          state_next_s = START;
        end
      end
      DATA: begin
        if (sample_s && last_bit_s) begin
          if (par_en_l_r) state_next_s = PARITY;
          else            state_next_s = STOP1;
        end else begin
          state_next_s = DATA;
        end
      end
      PARITY: begin
        if (sample_s) state_next_s = STOP1;
        else          state_next_s = PARITY;
      end
      STOP1: begin
        if (sample_s) begin
          ferr_s = !rxs_r;
          if (stop2_l_r && rxs_r) begin
            state_next_s = STOP2;
          end else begin
            push_s = 1'b1;
            // A low stop bit parks in WAIT_HIGH so a held-low line cannot retrigger.
            if (rxs_r) state_next_s = IDLE;
            else       state_next_s = WAIT_HIGH;
          end
        end else begin
          state_next_s = STOP1;
        end
      end
      STOP2: begin
        if (sample_s) begin
          ferr_s = !rxs_r;
          push_s = 1'b1;
          if (rxs_r) state_next_s = IDLE;
          else       state_next_s = WAIT_HIGH;
        end else begin
          state_next_s = STOP2;
        end
      end
      default: begin
        state_next_s = WAIT_HIGH;
      end
    endcase
  end

  // Frame datapath: config latch, bit counter, shift register, parity check
  always_ff @(posedge bit_clock) begin
    if (reset) begin
      cnt_r       <= {DIV_W{1'b0}};
      div_l_r     <= DIV_FLOOR;
      nbits_l_r   <= DATA_BITS_MAX;
      par_en_l_r  <= 1'b0;
      par_odd_l_r <= 1'b0;
      stop2_l_r   <= 1'b0;
      idx_r       <= 3'd0;
      shift_r     <= 8'd0;
      perr_r      <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (start_s) begin
            cnt_r       <= {DIV_W{1'b0}};
            div_l_r     <= div_eff_s;
            nbits_l_r   <= clamp_data_bits(data_bits);
            par_en_l_r  <= parity_enabled;
            par_odd_l_r <= parity_odd;
            stop2_l_r   <= stop_bits;
            idx_r       <= 3'd0;
            shift_r     <= 8'd0;
            perr_r      <= 1'b0;
          end
        end
        START, DATA, PARITY, STOP1, STOP2: begin
          if (sample_s) cnt_r <= {DIV_W{1'b0}};
          else          cnt_r <= cnt_r + CNT_ONE;
        end
        default: begin
          cnt_r <= {DIV_W{1'b0}};
        end
      endcase
      if ((state_r == DATA) && sample_s) begin
        shift_r[idx_r] <= rxs_r;
        idx_r          <= idx_r + 3'd1;
      end
      if ((state_r == PARITY) && sample_s) begin
        perr_r <= par_en_l_r && parity_mismatch(shift_r, rxs_r, par_odd_l_r);
      end
    end
  end

  assign push_entry_s = {ferr_s, perr_r, shift_r};

  mux_rx_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .WIDTH      (ENTRY_W)
  ) u_fifo (
    .clk       (bit_clock),
    .reset     (reset),
    .push      (push_s),
    .push_data (push_entry_s),
    .pop       (rd_en),
    .head      (head_s),
    .full      (fifo_full_s),
    .empty     (fifo_empty_s),
    .drop      (drop_s)
  );

  // Busy and sticky overrun; an overflow wins over a same-cycle clear
  always_ff @(posedge bit_clock) begin
    if (reset) begin
      busy_r    <= 1'b0;
      overrun_r <= 1'b0;
    end else begin
      busy_r <= !((state_next_s == IDLE) || (state_next_s == WAIT_HIGH));
      if (drop_s) begin
        overrun_r <= 1'b1;
      end else if (clear_overrun) begin
        overrun_r <= 1'b0;
      end
    end
  end

  assign rx_data       = head_s.data;
  assign parity_error  = head_s.perr;
  assign framing_error = head_s.ferr;
  assign rx_valid      = !fifo_empty_s;
  assign rx_busy       = busy_r;
  assign overrun       = overrun_r;

endmodule

// File: doc/mux_uart_rx.md
Name: mux_uart_rx

Overview:
- Serial receive channel for the MUX serial board: deserialises one asynchronous line into bytes for the CPU-side register file.
- Supports the board's configurable framing: 5–8 data bits, optional even/odd parity, 1 or 2 stop bits, baud set by a clock divider.
- Runs entirely on the 27 MHz bit_clock and pushes each received character, with its error flags, into a small FIFO.
- The CPU interface pops the FIFO and exposes the status bits.

Parameters:
- FIFO_DEPTH, 4, entries in the receive FIFO; must be a power of two, ≥2.
- DIV_W, 16, width of the divider input.

Ports:
- bit_clock  in  1  27 MHz clock; the block's only clock.
- reset  in  1  synchronous, active-high reset.
- uart_rx  in  1  asynchronous serial input, idle high.
- divider  in  DIV_W  bit_clock cycles per bit, e.g. 2812 = 9600 baud. Values <4 are treated as 4.
- data_bits  in  4  data bits per character, 5..8. Values <5 are treated as 5; values >8 are treated as 8.
- parity_enabled  in  1  1 = a parity bit follows the data.
- parity_odd  in  1  0 = even parity, 1 = odd parity.
- stop_bits  in  1  0 = one stop bit, 1 = two stop bits.
- rd_en  in  1  pop the FIFO head this cycle.
- clear_overrun  in  1  clears the overrun flag.
- rx_data  out  8  FIFO head data; unused upper bits are 0.
- rx_valid  out  1  FIFO not empty.
- parity_error  out  1  parity error flag of the head entry.
- framing_error  out  1  framing error flag of the head entry.
- overrun  out  1  sticky: a character was dropped because the FIFO was full.
- rx_busy  out  1  a frame is in progress (state is not IDLE or WAIT_HIGH).

Behaviour:
Reset:
- FIFO empty; state WAIT_HIGH.
- rx_data=0, rx_valid=0, parity_error=0, framing_error=0, overrun=0, rx_busy=0.
- Both synchroniser flops preset to 1.

Input path:
- uart_rx passes through a 2-flop synchroniser (rxs). All decisions use rxs.

Configuration latch:
- divider, data_bits, parity_enabled, parity_odd and stop_bits are captured on the cycle the start edge is detected.
- Changes made mid-frame take effect at the next frame.

Bit counter:
- The counter reloads at each sample point.
- Sample points: half = latched_divider>>1 cycles after the start edge, then every latched_divider cycles.

States:
- WAIT_HIGH: go to IDLE when rxs=1.
- IDLE: on rxs=0, go to START and clear the counter.
- START: at the half-bit point:
  - rxs=1 → false start; go to IDLE, push nothing.
  - rxs=0 → go to DATA with bit index 0.
- DATA: sample rxs into shift[index], LSB first.
  - After the last data bit: go to PARITY if parity is enabled, else STOP1.
- PARITY: perr = (XOR of the received data bits XOR the parity bit) != parity_odd. Go to STOP1.
- STOP1: sample rxs; ferr = (rxs==0).
  - If two stop bits are configured and ferr=0, go to STOP2.
  - Otherwise push the character.
- STOP2: sample rxs; ferr |= (rxs==0). Push the character.
- Push: the FIFO is written in the sample cycle with {ferr, perr, data}. Next state is IDLE if ferr=0, else WAIT_HIGH, so a break or line-low condition does not retrigger.
- perr is forced to 0 when parity is disabled.

FIFO:
- rx_valid, rx_data and the flags reflect the head entry one cycle after a push into an empty FIFO.
- rd_en with rx_valid=1: the head advances at the clock edge; the next entry (or zeros if empty) is visible the following cycle.
- rd_en with the FIFO empty: ignored.
- Push while full without a simultaneous pop: the character is dropped, overrun is set to 1, and existing entries are unchanged.
- Push while full with rd_en in the same cycle: pop and push both occur, with no overrun.
- Read and write pointers are log2(FIFO_DEPTH)+1 bits and wrap naturally; full/empty is decided by the extra MSB.

Overrun:
- clear_overrun clears the flag.
- If clear_overrun and an overflow occur in the same cycle, overrun ends at 1.

Reset mid-frame:
- The partial character is discarded, the FIFO is emptied, and the state returns to WAIT_HIGH.

Decomposition:
- Shared package mux_pkg:
  - rx state enum: WAIT_HIGH, IDLE, START, DATA, PARITY, STOP1, STOP2.
  - Baud divider constants DIV_75 … DIV_38400, computed as 27_000_000/baud.
  - Framing field widths.
- Sub-module mux_rx_fifo: synchronous FIFO, 10-bit entries, parameter FIFO_DEPTH, with push/pop/full/empty. The receiver FSM stays in mux_uart_rx.

Test Plan:
1. divider=16, 8N1, send 0xA5 → rx_valid=1, rx_data=0xA5, both error flags 0; rd_en pulse → rx_valid=0.
2. divider=16, 7 data bits, even parity, 1 stop (7E1), send 0x41 with parity=0 → rx_data=0x41, parity_error=0. Repeat with the parity bit flipped → rx_data=0x41, parity_error=1.
3. divider=16, 5 data bits, odd parity, 2 stops (5O2), send 0x1F with the second stop bit driven low → framing_error=1. The FSM waits for high; a low pulse of 40 cycles after the frame produces no second entry.
4. 8N1, line pulses low for 6 cycles (less than half a bit at divider=16) → false start, no push, rx_valid stays 0.
5. FIFO_DEPTH=4, send 5 bytes 0x01..0x05 without reads → rx_valid=1, overrun=1, and reads return 0x01..0x04. clear_overrun → overrun=0.
6. Assert reset for one cycle midway through receiving 0x55 → rx_valid=0, rx_busy=0; the next frame 0x33 is received correctly.
